// File: rtl/hyper_titan_nocs_pkg.sv
// Shared AXI-Lite link types and the arbiter state encoding for the peripheral-link fabric.
package hyper_titan_nocs_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic        aw_valid;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        w_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_ready;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        r_ready;
  } pl_s_axil_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
  } pl_s_axil_resp_t;

  // The shared link carries the same channel set as each requester port.
  typedef pl_s_axil_req_t  pl_m_axil_req_t;
  typedef pl_s_axil_resp_t pl_m_axil_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } pl_arb_state_e;

endpackage

// File: rtl/pl_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module pl_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int cand;

  // Walk offsets from farthest to nearest so the closest request to ptr is written last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % int'(N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pl_axil_arbiter.sv
// N-to-1 AXI-Lite arbiter, one outstanding transaction, round-robin grant.
// Define PL_ARB_TIMEOUT_EN to build in the response-phase watchdog with stale-beat absorption.
module pl_axil_arbiter
  import hyper_titan_nocs_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  pl_s_axil_req_t  [NUM_REQ-1:0]  req_i,
  output pl_s_axil_resp_t [NUM_REQ-1:0]  resp_o,
  output pl_m_axil_req_t                 req_o,
  input  pl_m_axil_resp_t                resp_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("pl_axil_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES at least 2");
  end

  pl_arb_state_e   state_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   next_ptr;
  logic            aw_done_q;
  logic            w_done_q;

  logic [NUM_REQ-1:0] pend_wr;
  logic [NUM_REQ-1:0] pend_rd;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               pick_wr;

  pl_s_axil_req_t  sel_req;
  pl_s_axil_resp_t sel_resp;
  logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic            timed_out, stale_b, stale_r;

  // A direction blocked by a pending stale beat must not win arbitration.
  always_comb begin
    pend_wr = '0;
    pend_rd = '0;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      pend_wr[r] = req_i[r].aw_valid & ~stale_b;
      pend_rd[r] = req_i[r].ar_valid & ~stale_r;
    end
  end

  assign pending  = pend_wr | pend_rd;
  assign pick_wr  = |(pick_gnt & pend_wr);
  assign sel_req  = req_i[grant_q];
  assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

  pl_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req   (pending),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign aw_hs = (state_q == WR_ADDR) & ~aw_done_q & sel_req.aw_valid & resp_i.aw_ready;
  assign w_hs  = (state_q == WR_ADDR) & ~w_done_q  & sel_req.w_valid  & resp_i.w_ready;
  assign ar_hs = (state_q == RD_ADDR) & sel_req.ar_valid & resp_i.ar_ready;
  assign b_hs  = (state_q == WR_RESP) & sel_resp.b_valid & sel_req.b_ready;
  assign r_hs  = (state_q == RD_RESP) & sel_resp.r_valid & sel_req.r_ready;

  always_comb begin
    req_o    = '0;
    sel_resp = '0;
    case (state_q)
      WR_ADDR: begin
        req_o.aw_valid    = sel_req.aw_valid & ~aw_done_q;
        req_o.aw_addr     = sel_req.aw_addr;
        req_o.aw_prot     = sel_req.aw_prot;
        req_o.w_valid     = sel_req.w_valid & ~w_done_q;
        req_o.w_data      = sel_req.w_data;
        req_o.w_strb      = sel_req.w_strb;
        sel_resp.aw_ready = resp_i.aw_ready & ~aw_done_q;
        sel_resp.w_ready  = resp_i.w_ready & ~w_done_q;
      end
      WR_RESP: begin
        if (timed_out) begin
          sel_resp.b_valid = 1'b1;
          sel_resp.b_resp  = AXI_RESP_SLVERR;
        end else begin
          sel_resp.b_valid = resp_i.b_valid;
          sel_resp.b_resp  = resp_i.b_resp;
          req_o.b_ready    = sel_req.b_ready;
        end
      end
      RD_ADDR: begin
        req_o.ar_valid    = sel_req.ar_valid;
        req_o.ar_addr     = sel_req.ar_addr;
        req_o.ar_prot     = sel_req.ar_prot;
        sel_resp.ar_ready = resp_i.ar_ready;
      end
      RD_RESP: begin
        if (timed_out) begin
          sel_resp.r_valid = 1'b1;
          sel_resp.r_resp  = AXI_RESP_SLVERR;
          sel_resp.r_data  = '0;
        end else begin
          sel_resp.r_valid = resp_i.r_valid;
          sel_resp.r_resp  = resp_i.r_resp;
          sel_resp.r_data  = resp_i.r_data;
          req_o.r_ready    = sel_req.r_ready;
        end
      end
      default: ;
    endcase
    req_o.b_ready = req_o.b_ready | stale_b;
    req_o.r_ready = req_o.r_ready | stale_r;
  end

  always_comb begin
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      resp_o[r] = (IW'(r) == grant_q) ? sel_resp : '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= pick_wr ? WR_ADDR : RD_ADDR;
          end
        end
        WR_ADDR: begin
          aw_done_q <= aw_done_q | aw_hs;
          w_done_q  <= w_done_q | w_hs;
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        RD_ADDR: begin
          if (ar_hs) state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (r_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PL_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          stale_b_q, stale_r_q;
  logic          in_resp;

  assign in_resp   = (state_q == WR_RESP) || (state_q == RD_RESP);
  assign timed_out = in_resp && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign stale_b   = stale_b_q;
  assign stale_r   = stale_r_q;

  // Counter holds at the limit while the synthetic error response waits for the requester.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q     <= '0;
      stale_b_q <= 1'b0;
      stale_r_q <= 1'b0;
    end else begin
      if (!in_resp)        cnt_q <= '0;
      else if (!timed_out) cnt_q <= cnt_q + CW'(1);

      if (timed_out && b_hs)               stale_b_q <= 1'b1;
      else if (stale_b_q && resp_i.b_valid) stale_b_q <= 1'b0;

      if (timed_out && r_hs)               stale_r_q <= 1'b1;
      else if (stale_r_q && resp_i.r_valid) stale_r_q <= 1'b0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign stale_b   = 1'b0;
  assign stale_r   = 1'b0;
`endif

endmodule

// File: tb/tb_pl_axil_arbiter.sv
// Directed self-checking bench for pl_axil_arbiter (4 requesters, 16-cycle watchdog when enabled).
module tb_pl_axil_arbiter;
  import hyper_titan_nocs_pkg::*;

  localparam int NR = 4;

  logic clk = 1'b0;
  logic arst_n;
  pl_s_axil_req_t  [NR-1:0] req;
  pl_s_axil_resp_t [NR-1:0] resp;
  pl_m_axil_req_t           mreq;
  pl_m_axil_resp_t          mresp;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pl_axil_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .req_i   (req),
    .resp_o  (resp),
    .req_o   (mreq),
    .resp_i  (mresp)
  );

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the slave side of the shared link and let combinational paths settle.
  task automatic applyStimulus(input pl_m_axil_resp_t r);
    mresp = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [4:0] mbits(input pl_m_axil_req_t m);
    return {m.aw_valid, m.w_valid, m.b_ready, m.ar_valid, m.r_ready};
  endfunction

  function automatic logic [4:0] sbits(input pl_s_axil_resp_t s);
    return {s.aw_ready, s.w_ready, s.b_valid, s.ar_ready, s.r_valid};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pl_m_axil_resp_t s;
    int g;

    // Reset held for 5 cycles with every input asserted.
    arst_n = 1'b0;
    for (int r = 0; r < NR; r++) begin
      req[r]          = '0;
      req[r].aw_valid = 1'b1;
      req[r].w_valid  = 1'b1;
      req[r].b_ready  = 1'b1;
      req[r].ar_valid = 1'b1;
      req[r].r_ready  = 1'b1;
    end
    s = '0;
    s.aw_ready = 1'b1; s.w_ready = 1'b1; s.b_valid = 1'b1; s.ar_ready = 1'b1; s.r_valid = 1'b1;
    applyStimulus(s);
    repeat (5) tick();
    checkOutput("rst_m_handshakes", mbits(mreq), 5'b0);
    for (int r = 0; r < NR; r++) checkOutput($sformatf("rst_s%0d_handshakes", r), sbits(resp[r]), 5'b0);
    checkOutput("rst_state", 64'(dut.state_q), 64'(IDLE));

    for (int r = 0; r < NR; r++) req[r] = '0;
    applyStimulus('0);
    arst_n = 1'b1;
    tick();
    checkOutput("post_rst_idle", mbits(mreq), 5'b0);

    // Round robin: all four keep ar_valid high; expected order 0,1,2,3,0.
    for (int r = 0; r < NR; r++) begin
      req[r].ar_valid = 1'b1;
      req[r].ar_addr  = 32'h1000 + 32'(r) * 32'h100;
      req[r].r_ready  = 1'b1;
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % NR;
      tick();
      s = '0; s.ar_ready = 1'b1;
      applyStimulus(s);
      checkOutput($sformatf("rr%0d_ar_addr", k), mreq.ar_addr, 32'h1000 + 32'(g) * 32'h100);
      checkOutput($sformatf("rr%0d_ar_ready", k), resp[g].ar_ready, 1'b1);
      for (int r = 0; r < NR; r++)
        if (r != g) checkOutput($sformatf("rr%0d_other%0d", k, r), sbits(resp[r]), 5'b0);
      tick();
      s = '0; s.r_valid = 1'b1; s.r_data = 32'hC0DE_0000 + 32'(k);
      applyStimulus(s);
      checkOutput($sformatf("rr%0d_r_valid", k), resp[g].r_valid, 1'b1);
      checkOutput($sformatf("rr%0d_r_data", k), resp[g].r_data, 32'hC0DE_0000 + 32'(k));
      for (int r = 0; r < NR; r++)
        if (r != g) checkOutput($sformatf("rr%0d_r_other%0d", k, r), resp[r].r_valid, 1'b0);
      tick();
      applyStimulus('0);
      checkOutput($sformatf("rr%0d_idle_no_fwd", k), mreq.ar_valid, 1'b0);
    end
    for (int r = 0; r < NR; r++) req[r] = '0;
    #1;

    // Split write from requester 2: aw at cycle 10, w at cycle 14 (rr_ptr is now 1).
    req[2].aw_valid = 1'b1;
    req[2].aw_addr  = 32'h2000_0010;
    req[2].b_ready  = 1'b1;
    #1;
    tick();
    s = '0; s.aw_ready = 1'b1;
    applyStimulus(s);
    checkOutput("wr_aw_fwd", {mreq.aw_valid, mreq.w_valid}, 2'b10);
    checkOutput("wr_aw_addr", mreq.aw_addr, 32'h2000_0010);
    checkOutput("wr_aw_ready", resp[2].aw_ready, 1'b1);
    tick();
    req[2].aw_valid = 1'b0;
    applyStimulus('0);
    checkOutput("wr_aw_done_state", 64'(dut.state_q), 64'(WR_ADDR));
    tick();
    tick();
    req[2].w_valid = 1'b1;
    req[2].w_data  = 32'hCAFE_F00D;
    req[2].w_strb  = 4'hF;
    #1;
    checkOutput("wr_w_fwd", {mreq.w_valid, mreq.w_data}, {1'b1, 32'hCAFE_F00D});
    checkOutput("wr_w_ready_low", resp[2].w_ready, 1'b0);
    tick();
    s = '0; s.w_ready = 1'b1;
    applyStimulus(s);
    checkOutput("wr_w_ready", resp[2].w_ready, 1'b1);
    checkOutput("wr_c15_state", 64'(dut.state_q), 64'(WR_ADDR));
    tick();
    req[2].w_valid = 1'b0;
    s = '0; s.b_valid = 1'b1; s.b_resp = AXI_RESP_OKAY;
    applyStimulus(s);
    checkOutput("wr_c16_state", 64'(dut.state_q), 64'(WR_RESP));
    checkOutput("wr_b_fwd", {resp[2].b_valid, resp[2].b_resp}, 3'b100);
    for (int r = 0; r < NR; r++)
      if (r != 2) checkOutput($sformatf("wr_b_other%0d", r), sbits(resp[r]), 5'b0);
    checkOutput("wr_b_ready", mreq.b_ready, 1'b1);
    tick();
    req[2] = '0;
    applyStimulus('0);
    checkOutput("wr_back_idle", 64'(dut.state_q), 64'(IDLE));

    // Requester 1 raises aw, w and ar together; b is back-pressured for 8 cycles (rr_ptr is 3).
    req[1].aw_valid = 1'b1; req[1].aw_addr = 32'h3000_0000;
    req[1].w_valid  = 1'b1; req[1].w_data  = 32'h1234_5678; req[1].w_strb = 4'hF;
    req[1].ar_valid = 1'b1; req[1].ar_addr = 32'h3000_0004;
    req[1].b_ready  = 1'b0; req[1].r_ready = 1'b1;
    #1;
    tick();
    s = '0; s.aw_ready = 1'b1; s.w_ready = 1'b1;
    applyStimulus(s);
    checkOutput("pri_write_first", {mreq.aw_valid, mreq.w_valid, mreq.ar_valid}, 3'b110);
    checkOutput("pri_aw_addr", mreq.aw_addr, 32'h3000_0000);
    checkOutput("pri_aw_w_ready", {resp[1].aw_ready, resp[1].w_ready}, 2'b11);
    tick();
    req[1].aw_valid = 1'b0;
    req[1].w_valid  = 1'b0;
    req[0].ar_valid = 1'b1; req[0].ar_addr = 32'h4000_0000; req[0].r_ready = 1'b1;
    s = '0; s.b_valid = 1'b1; s.b_resp = 2'b01;
    applyStimulus(s);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("bp%0d_b_ready", i), mreq.b_ready, 1'b0);
      checkOutput($sformatf("bp%0d_b_valid", i), resp[1].b_valid, 1'b1);
      checkOutput($sformatf("bp%0d_no_grant", i), mreq.ar_valid, 1'b0);
      tick();
    end
    req[1].b_ready = 1'b1;
    #1;
    checkOutput("bp_release", {mreq.b_ready, resp[1].b_resp}, 3'b101);
    tick();
    applyStimulus('0);
    checkOutput("bp_idle", 64'(dut.state_q), 64'(IDLE));
    tick();
    s = '0; s.ar_ready = 1'b1;
    applyStimulus(s);
    checkOutput("pri_rd0_addr", mreq.ar_addr, 32'h4000_0000);
    tick();
    req[0].ar_valid = 1'b0;
    s = '0; s.r_valid = 1'b1; s.r_data = 32'h0000_AAAA;
    applyStimulus(s);
    tick();
    applyStimulus('0);
    tick();
    s = '0; s.ar_ready = 1'b1;
    applyStimulus(s);
    checkOutput("pri_rd1_addr", mreq.ar_addr, 32'h3000_0004);
    checkOutput("pri_rd1_ar_ready", resp[1].ar_ready, 1'b1);
    tick();
    req[1].ar_valid = 1'b0;
    s = '0; s.r_valid = 1'b1; s.r_data = 32'h5555_AAAA;
    applyStimulus(s);
    checkOutput("pri_rd1_r_data", {resp[1].r_valid, resp[1].r_data}, {1'b1, 32'h5555_AAAA});
    tick();
    for (int r = 0; r < NR; r++) req[r] = '0;
    applyStimulus('0);

`ifdef PL_ARB_TIMEOUT_EN
    // Watchdog: requester 3 reads, slave stays silent; rr_ptr is 2.
    req[3].ar_valid = 1'b1; req[3].ar_addr = 32'h5000_0000; req[3].r_ready = 1'b1;
    #1;
    tick();
    s = '0; s.ar_ready = 1'b1;
    applyStimulus(s);
    checkOutput("to_ar_addr", mreq.ar_addr, 32'h5000_0000);
    tick();
    req[3].ar_valid = 1'b0;
    applyStimulus('0);
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("to_wait%0d", i), resp[3].r_valid, 1'b0);
      tick();
    end
    checkOutput("to_err_resp", {resp[3].r_valid, resp[3].r_resp, resp[3].r_data}, {1'b1, 2'b10, 32'h0});
    checkOutput("to_link_r_ready", mreq.r_ready, 1'b0);
    tick();
    req[3] = '0;
    req[0].ar_valid = 1'b1; req[0].ar_addr = 32'h6000_0000; req[0].r_ready = 1'b1;
    #1;
    checkOutput("to_stale_ready", mreq.r_ready, 1'b1);
    tick();
    checkOutput("to_read_blocked", {64'(dut.state_q), mreq.ar_valid}, {64'(IDLE), 1'b0});
    s = '0; s.r_valid = 1'b1; s.r_data = 32'hBAD0_BAD0;
    applyStimulus(s);
    for (int r = 0; r < NR; r++) checkOutput($sformatf("to_absorb%0d", r), resp[r].r_valid, 1'b0);
    tick();
    applyStimulus('0);
    checkOutput("to_stale_cleared", mreq.r_ready, 1'b0);
    tick();
    s = '0; s.ar_ready = 1'b1;
    applyStimulus(s);
    checkOutput("to_next_read", mreq.ar_addr, 32'h6000_0000);
    tick();
    req[0].ar_valid = 1'b0;
    s = '0; s.r_valid = 1'b1; s.r_data = 32'h0000_0006;
    applyStimulus(s);
    checkOutput("to_after_r", {resp[0].r_valid, resp[0].r_data}, {1'b1, 32'h0000_0006});
    tick();
    for (int r = 0; r < NR; r++) req[r] = '0;
    applyStimulus('0);
`endif

    // Reset in the middle of a write address phase abandons it immediately.
    req[2].aw_valid = 1'b1; req[2].aw_addr = 32'h7000_0000;
    req[2].w_valid  = 1'b1; req[2].b_ready = 1'b1;
    #1;
    tick();
    s = '0; s.aw_ready = 1'b1; s.w_ready = 1'b1;
    applyStimulus(s);
    checkOutput("mid_pre_fwd", {mreq.aw_valid, mreq.w_valid}, 2'b11);
    arst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m", mbits(mreq), 5'b0);
    checkOutput("mid_rst_s2", sbits(resp[2]), 5'b0);
    checkOutput("mid_rst_state", 64'(dut.state_q), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
